// File: rtl/seg_decode_capture.sv
`default_nettype none
// ============================================================================
// Module      : seg_decode_capture
// Description : Decodes a multiplexed active-low 7-segment bus back to hex
//               nibbles once a pattern is stable, keeps a per-digit image and
//               emits each capture on a one-entry valid/ready port.
//               Optional macro SEG_DECODE_BLANK_EN treats 7'h7F as a legal blank.
// Revision    : 1.0  initial release
// ============================================================================
module seg_decode_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     sel,
    input  logic                  clr_flags,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_digit,
    output logic [3:0]            out_value,
    output logic [4*DIGITS-1:0]   image,
    output logic [DIGITS-1:0]     image_vld,
    output logic                  err,
    output logic                  ovf
);

    localparam int               CNT_W      = 8;
    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
`ifdef SEG_DECODE_BLANK_EN
    localparam logic [6:0]       SEG_BLANK  = 7'h7F;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [6:0]            s_seg_q, s_seg_d, p_seg_q, p_seg_d;
    logic [DIGITS-1:0]     s_sel_q, s_sel_d, p_sel_q, p_sel_d;
    logic                  out_valid_q, out_valid_d;
    logic [2:0]            out_digit_q, out_digit_d;
    logic [3:0]            out_value_q, out_value_d;
    logic [4*DIGITS-1:0]   image_q, image_d;
    logic [DIGITS-1:0]     image_vld_q, image_vld_d;
    logic                  err_q, err_d;
    logic                  ovf_q, ovf_d;

    logic                  sel_onehot;
    logic                  changed;
    logic                  capture;
    logic [2:0]            sel_idx;
    logic [4:0]            dec;
    logic                  is_blank;
    logic                  cap_load, cap_err, cap_blank;

    // Returns {legal, nibble} for an active-low segment pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        s_seg_d    = seg;
        s_sel_d    = sel;
        p_seg_d    = s_seg_q;
        p_sel_d    = s_sel_q;
        sel_onehot = (s_sel_q != '0) && ((s_sel_q & (s_sel_q - 1'b1)) == '0);
        changed    = (s_seg_q != p_seg_q) || (s_sel_q != p_sel_q);
        sel_idx    = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (s_sel_q[i]) sel_idx = 3'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_onehot) begin
                    state_d = ST_COUNT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_COUNT: begin
                if (!sel_onehot) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (changed) begin
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_d == STABLE_CNT) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Only a new (seg, sel) pair re-arms the counter: one capture per dwell.
                if (changed) begin
                    if (sel_onehot) begin
                        state_d = ST_COUNT;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        dec = decode_seg(s_seg_q);
`ifdef SEG_DECODE_BLANK_EN
        is_blank = (s_seg_q == SEG_BLANK);
`else
        is_blank = 1'b0;
`endif
        cap_load  = capture && dec[4];
        cap_err   = capture && !dec[4] && !is_blank;
        cap_blank = capture && is_blank;

        out_valid_d = out_valid_q;
        out_digit_d = out_digit_q;
        out_value_d = out_value_q;
        image_d     = image_q;
        image_vld_d = image_vld_q;
        err_d       = clr_flags ? 1'b0 : err_q;
        ovf_d       = clr_flags ? 1'b0 : ovf_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (cap_load) begin
            out_valid_d = 1'b1;
            out_digit_d = sel_idx;
            out_value_d = dec[3:0];
            if (out_valid_q && !out_ready) ovf_d = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if (s_sel_q[i]) begin
                    image_d[4*i +: 4] = dec[3:0];
                    image_vld_d[i]    = 1'b1;
                end
            end
        end

        if (cap_err) err_d = 1'b1;

        if (cap_blank) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (s_sel_q[i]) image_vld_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            s_seg_q     <= 7'h7F;
            s_sel_q     <= '0;
            p_seg_q     <= 7'h7F;
            p_sel_q     <= '0;
            out_valid_q <= 1'b0;
            out_digit_q <= 3'd0;
            out_value_q <= 4'd0;
            image_q     <= '0;
            image_vld_q <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_seg_q     <= s_seg_d;
            s_sel_q     <= s_sel_d;
            p_seg_q     <= p_seg_d;
            p_sel_q     <= p_sel_d;
            out_valid_q <= out_valid_d;
            out_digit_q <= out_digit_d;
            out_value_q <= out_value_d;
            image_q     <= image_d;
            image_vld_q <= image_vld_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_digit = out_digit_q;
    assign out_value = out_value_q;
    assign image     = image_q;
    assign image_vld = image_vld_q;
    assign err       = err_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_decode_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_decode_capture
// Description : Directed self-checking bench for seg_decode_capture with an
//               output-entry scoreboard. Honours SEG_DECODE_BLANK_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg_decode_capture;

    logic        clk;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  sel;
    logic        clr_flags;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_digit;
    logic [3:0]  out_value;
    logic [15:0] image;
    logic [3:0]  image_vld;
    logic        err;
    logic        ovf;

    int checks   = 0;
    int failures = 0;
    logic [6:0] exp_q[$];

    seg_decode_capture #(
        .DIGITS        (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .seg       (seg),
        .sel       (sel),
        .clr_flags (clr_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digit (out_digit),
        .out_value (out_value),
        .image     (image),
        .image_vld (image_vld),
        .err       (err),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every accepted entry must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_entry", {25'd0, out_digit, out_value}, 32'hFFFF_FFFF);
            end else begin
                check("entry", {25'd0, out_digit, out_value}, {25'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [6:0] pats [4];
        logic [3:0] nibs [4];
        pats[0] = 7'h79; pats[1] = 7'h24; pats[2] = 7'h08; pats[3] = 7'h0E;
        nibs[0] = 4'h1;  nibs[1] = 4'h2;  nibs[2] = 4'hA;  nibs[3] = 4'hF;

        reset = 1'b1; seg = 7'h7F; sel = 4'b0000; clr_flags = 1'b0; out_ready = 1'b0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_digit", {29'd0, out_digit}, 32'd0);
        check("rst_out_value", {28'd0, out_value}, 32'd0);
        check("rst_image", {16'd0, image}, 32'd0);
        check("rst_image_vld", {28'd0, image_vld}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        tick(2);
        reset = 1'b0;

        // First capture: digit 0 shows '3'
        sel = 4'b0001; seg = 7'h30;
        tick(4);
        check("t1_not_yet", {31'd0, out_valid}, 32'd0);
        tick(1);
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_digit", {29'd0, out_digit}, 32'd0);
        check("t1_value", {28'd0, out_value}, 32'd3);
        check("t1_image", {28'd0, image[3:0]}, 32'd3);
        check("t1_vld", {28'd0, image_vld}, 32'b0001);
        tick(5);
        check("t1_no_second_ovf", {31'd0, ovf}, 32'd0);
        check("t1_still_valid", {31'd0, out_valid}, 32'd1);
        exp_q.push_back({3'd0, 4'h3});
        out_ready = 1'b1;
        tick(1);
        check("t1_accepted", {31'd0, out_valid}, 32'd0);

        // Scan all digits with the consumer always ready
        for (int d = 0; d < 4; d++) begin
            exp_q.push_back({3'(d), nibs[d]});
            sel = 4'b0001 << d;
            seg = pats[d];
            tick(6);
        end
        check("scan_image", {16'd0, image}, 32'h0000_FA21);
        check("scan_vld", {28'd0, image_vld}, 32'hF);
        check("scan_ovf", {31'd0, ovf}, 32'd0);
        check("scan_drained", {31'd0, out_valid}, 32'd0);

        // Glitch restarts the count
        sel = 4'b0001; seg = 7'h40;
        tick(3);
        seg = 7'h79;
        tick(1);
        seg = 7'h40;
        tick(4);
        check("glitch_no_early", {31'd0, out_valid}, 32'd0);
        exp_q.push_back({3'd0, 4'h0});
        tick(1);
        check("glitch_valid", {31'd0, out_valid}, 32'd1);
        check("glitch_value", {28'd0, out_value}, 32'd0);
        check("glitch_image", {16'd0, image}, 32'h0000_FA20);
        tick(1);
        check("glitch_drained", {31'd0, out_valid}, 32'd0);

        // Overwrite of an unaccepted entry
        out_ready = 1'b0;
        sel = 4'b0010; seg = 7'h12;
        tick(6);
        check("ovf_first_valid", {31'd0, out_valid}, 32'd1);
        check("ovf_first_value", {28'd0, out_value}, 32'd5);
        check("ovf_not_yet", {31'd0, ovf}, 32'd0);
        sel = 4'b0100; seg = 7'h02;
        tick(6);
        check("ovf_digit", {29'd0, out_digit}, 32'd2);
        check("ovf_value", {28'd0, out_value}, 32'd6);
        check("ovf_set", {31'd0, ovf}, 32'd1);
        check("ovf_image", {16'd0, image}, 32'h0000_F650);
        exp_q.push_back({3'd2, 4'h6});
        clr_flags = 1'b1; out_ready = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check("ovf_cleared", {31'd0, ovf}, 32'd0);
        check("ovf_accepted", {31'd0, out_valid}, 32'd0);

        // All-off pattern on digit 0
        sel = 4'b0001; seg = 7'h7F;
        tick(6);
        check("blank_no_entry", {31'd0, out_valid}, 32'd0);
        check("blank_image", {16'd0, image}, 32'h0000_F650);
`ifdef SEG_DECODE_BLANK_EN
        check("blank_err", {31'd0, err}, 32'd0);
        check("blank_vld", {28'd0, image_vld}, 32'hE);
`else
        check("blank_err", {31'd0, err}, 32'd1);
        check("blank_vld", {28'd0, image_vld}, 32'hF);
`endif
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check("err_cleared", {31'd0, err}, 32'd0);

        // Multi-hot select never captures
        sel = 4'b0011; seg = 7'h30;
        tick(10);
        check("multihot_no_entry", {31'd0, out_valid}, 32'd0);
        check("multihot_image", {16'd0, image}, 32'h0000_F650);
        check("multihot_err", {31'd0, err}, 32'd0);

        // Asynchronous reset in the middle of a count
        sel = 4'b1000; seg = 7'h19;
        tick(2);
        reset = 1'b1;
        #1;
        check("arst_image", {16'd0, image}, 32'd0);
        check("arst_vld", {28'd0, image_vld}, 32'd0);
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_flags", {30'd0, err, ovf}, 32'd0);
        tick(1);
        reset = 1'b0;
        tick(4);
        check("arst_recount", {31'd0, out_valid}, 32'd0);
        exp_q.push_back({3'd3, 4'h4});
        tick(1);
        check("arst_cap_valid", {31'd0, out_valid}, 32'd1);
        check("arst_cap_digit", {29'd0, out_digit}, 32'd3);
        check("arst_cap_image", {16'd0, image}, 32'h0000_4000);
        check("arst_cap_vld", {28'd0, image_vld}, 32'b1000);
        tick(2);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_decode_capture.md
# seg_decode_capture

Seven-segment pattern decoder and capture block: the inverse of the board's hex-to-segment encoder. Watches a multiplexed, active-low seven-segment bus plus one-hot digit select, waits for each pattern to be stable, decodes it back to a 4-bit hex value, and maintains a per-digit value image. Each capture is also emitted through a one-entry valid/ready port. Used on the processor display path for self-check and for readback of what the display is driving.

## Interface
- DIGITS, 4: number of multiplexed digits (1–8).
- STABLE_CYCLES, 4: consecutive identical samples required before capture (2–255).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- seg  in  7  segment lines, active-low; bit0=a … bit6=g.
- sel  in  DIGITS  digit select, active-high, one-hot when a digit is driven.
- clr_flags  in  1  clears err and ovf.
- out_valid  out  1  capture entry available.
- out_ready  in  1  consumer accepts entry.
- out_digit  out  3  index of captured digit.
- out_value  out  4  decoded nibble.
- image  out  4*DIGITS  last decoded nibble per digit; digit i at [4i+3:4i].
- image_vld  out  DIGITS  digit has been captured since reset.
- err  out  1  sticky: illegal pattern seen.
- ovf  out  1  sticky: capture overwrote an unaccepted entry.

## Operation
- Decode table, hex values of seg[6:0]: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E. Any other pattern is illegal.
- Input stage: seg and sel registered every cycle (s_seg, s_sel). The comparator uses the registered copies only.
- FSM states:
  - IDLE: s_sel not one-hot (zero or multi-hot); counter held at 0.
  - COUNT: s_sel one-hot. Counter increments each cycle the new sample equals the previous one; on any mismatch, counter returns to 1 and state stays COUNT, or goes to IDLE if the new s_sel is not one-hot.
  - HOLD: capture done. Stays until (s_seg, s_sel) changes, then goes to COUNT or IDLE as above. Exactly one capture per dwell.
- Capture, taken when the counter reaches STABLE_CYCLES:
  - Legal pattern: image[digit] ← nibble; image_vld[digit] ← 1; out_digit/out_value loaded; out_valid ← 1.
  - Illegal pattern: err ← 1; no image or output update; FSM still enters HOLD.
- Handshake:
  - out_valid && out_ready at an edge clears out_valid.
  - Capture in the same cycle as an accept loads the new entry, out_valid stays 1, no ovf.
  - Capture while out_valid=1 && !out_ready: entry is overwritten and ovf ← 1.
- clr_flags clears err/ovf. If a set condition occurs in the same cycle, set wins.
- Digit index is the position of the set bit in s_sel.

## Timing
- Reset values: out_valid=0, out_digit=0, out_value=0, image=0, image_vld=0, err=0, ovf=0; FSM=IDLE; counter=0; s_seg=7'h7F, s_sel=0.
- Latency: a pair first present at edge E is sampled at E. Capture outputs become visible after edge E+STABLE_CYCLES.
- A change at any edge before capture restarts the count, with no capture.
- Reset asserted mid-count or mid-handshake: all state returns to reset values immediately (asynchronously). The pending entry is lost.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SEG_DECODE_BLANK_EN defined:
  - Pattern 7F (all segments off) is legal blank.
  - Clears image_vld[digit] and leaves image[digit] unchanged.
  - No output entry and no err.
- Not defined: 7F is illegal and sets err.

## Test plan
- Reset, sel=4'b0001, seg=7'h30 held 4 cycles (STABLE_CYCLES=4) -> after 5th edge: out_valid=1, out_digit=0, out_value=3, image[3:0]=3, image_vld=0001; holding longer gives no second capture.
- Scan digits 0..3 with 79,24,08,0E, 6 cycles each, out_ready=1 -> image=16'hFA21, image_vld=1111, four entries accepted, ovf=0.
- Glitch: seg=40 for 3 cycles, 79 for 1 cycle, then 40 for 4 cycles -> single capture of 0, after the final 4 cycles only.
- out_ready=0, two captures (digit1=5, digit2=6) -> out_digit=2, out_value=6, ovf=1. Then clr_flags with out_ready=1 -> ovf=0, out_valid=0.
- seg=7'h7F on digit 0, stable -> err=1 without SEG_DECODE_BLANK_EN; with it, err=0 and image_vld[0]=0.
- sel=4'b0011 for 10 cycles -> no capture. Reset asserted during COUNT -> all outputs at reset values on the same cycle.
